// File: rtl/uart_word_streamer.sv
// -----------------------------------------------------------------------------
// uart_word_streamer
//
// Streams a block of words from a synchronous-read memory onto a UART line,
// one byte per frame, then appends a fixed terminator word. It is the on-chip
// loader source that feeds instruction images to a UART boot receiver.
//
// Frame: start bit (0), 8 data bits LSB first, [even parity], stop bit (1).
// Every bit lasts CLKS_PER_BIT clocks.
//
// Optional feature macro:
//   UART_STREAM_PARITY_EN - when defined, an even-parity bit (XOR of the 8 data
//                           bits) is sent between data bit 7 and the stop bit.
//                           When undefined, frames are 8N1 only.
//
// Parameters:
//   CLKS_PER_BIT  clocks per UART bit (>= 2)
//   WORD_W        word width, multiple of 8
//   MSB_FIRST     1: most significant byte sent first, 0: least significant
//   CNT_W         width of word count and read address
//   TERMINATOR    word sent after the block (zero-extended/truncated to WORD_W)
//
// Ports:
//   clk_i         clock
//   rst_i         asynchronous active-high reset
//   start_i       one-cycle start request, ignored while busy_o is high
//   word_count_i  number of words to send, sampled with start_i
//   rd_en_o       memory read strobe, one cycle per word
//   rd_addr_o     memory word address
//   rd_data_i     memory read data, valid one cycle after rd_en_o
//   tx_o          UART serial output, idle high
//   busy_o        high while a stream is in progress
//   done_o        one-cycle pulse after the terminator's stop bit
// -----------------------------------------------------------------------------
module uart_word_streamer #(
    parameter int unsigned CLKS_PER_BIT = 86,
    parameter int unsigned WORD_W       = 32,
    parameter bit          MSB_FIRST    = 1'b1,
    parameter int unsigned CNT_W        = 16,
    parameter logic [31:0] TERMINATOR   = 32'h0000_0FFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  word_count_i,
    output logic              rd_en_o,
    output logic [CNT_W-1:0]  rd_addr_o,
    input  logic [WORD_W-1:0] rd_data_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned NBYTES = WORD_W / 8;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    // Widen first so the terminator can be either zero-extended or truncated.
    localparam logic [WORD_W+31:0] TERM_EXT  = {{WORD_W{1'b0}}, TERMINATOR};
    localparam logic [WORD_W-1:0]  TERM_WORD = TERM_EXT[WORD_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_STREAM_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    // Byte that goes out next from a word, according to byte order.
    function automatic logic [7:0] first_byte(input logic [WORD_W-1:0] w);
        if (MSB_FIRST) begin
            first_byte = w[WORD_W-1 -: 8];
        end else begin
            first_byte = w[7:0];
        end
    endfunction

    // Word with the byte just sent shifted out.
    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
        if (MSB_FIRST) begin
            next_word = w << 8;
        end else begin
            next_word = w >> 8;
        end
    endfunction

`ifdef UART_STREAM_PARITY_EN
    // Even parity over one data byte.
    function automatic logic even_parity(input logic [7:0] b);
        even_parity = ^b;
    endfunction
`endif

    state_t             state_q;
    logic [BAUD_W-1:0]  baud_q;
    logic [2:0]         bit_q;
    logic [BYTE_W-1:0]  byte_cnt_q;
    logic [WORD_W-1:0]  word_q;
    logic [7:0]         byte_q;
    logic [CNT_W-1:0]   idx_q;
    logic [CNT_W-1:0]   count_q;
    logic               term_q;
    logic               tx_q;
    logic               rd_en_q;
    logic [CNT_W-1:0]   rd_addr_q;
    logic               busy_q;
    logic               done_q;
`ifdef UART_STREAM_PARITY_EN
    logic               parity_q;
`endif

    logic               bit_end;
    logic [CNT_W-1:0]   idx_d;
    logic [WORD_W-1:0]  load_word;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign idx_d     = idx_q + CNT_W'(1);
    // The terminator replaces memory data whenever the block is exhausted.
    assign load_word = term_q ? TERM_WORD : rd_data_i;

    // Stream controller: state, bit timer, shift registers and all outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            byte_q     <= 8'd0;
            idx_q      <= '0;
            count_q    <= '0;
            term_q     <= 1'b0;
            tx_q       <= 1'b1;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_STREAM_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rd_en_q <= 1'b0;
                    tx_q    <= 1'b1;
                    if (start_i) begin
                        count_q   <= word_count_i;
                        idx_q     <= '0;
                        rd_addr_q <= '0;
                        // An empty block still passes through FETCH (without a
                        // read) so the first start bit keeps the same latency.
                        rd_en_q   <= (word_count_i != '0);
                        term_q    <= (word_count_i == '0);
                        busy_q    <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_LOAD;
                end

                S_LOAD: begin
                    byte_q     <= first_byte(load_word);
                    word_q     <= next_word(load_word);
`ifdef UART_STREAM_PARITY_EN
                    parity_q   <= even_parity(first_byte(load_word));
`endif
                    byte_cnt_q <= '0;
                    baud_q     <= '0;
                    tx_q       <= 1'b0;
                    state_q    <= S_START;
                end

                S_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        bit_q   <= 3'd0;
                        tx_q    <= byte_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q  <= baud_q + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef UART_STREAM_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q  <= bit_q + 3'd1;
                            byte_q <= byte_q >> 1;
                            tx_q   <= byte_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

`ifdef UART_STREAM_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q  <= baud_q + BAUD_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (byte_cnt_q != BYTE_LAST) begin
                            // Next byte of the same word follows immediately.
                            byte_cnt_q <= byte_cnt_q + BYTE_W'(1);
                            byte_q     <= first_byte(word_q);
                            word_q     <= next_word(word_q);
`ifdef UART_STREAM_PARITY_EN
                            parity_q   <= even_parity(first_byte(word_q));
`endif
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end else if (term_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end else if (idx_d == count_q) begin
                            // Block exhausted: terminator needs no memory read.
                            idx_q   <= idx_d;
                            term_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end else begin
                            idx_q     <= idx_d;
                            rd_addr_q <= idx_d;
                            rd_en_q   <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                // One cycle with done_o high; start_i is not sampled here.
                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    rd_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_o      = tx_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
